// File: rtl/full_adder_half.sv
// Registered ripple-carry adder: each bit is two half adders plus an OR of their carries.
// Define FULL_ADDER_HALF_DEBUG_EN to expose registered per-bit HA1/HA2 terms on dbg_p/dbg_g/dbg_t.
module full_adder_half #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             valid
`ifdef FULL_ADDER_HALF_DEBUG_EN
    ,
    output logic [WIDTH-1:0] dbg_p,
    output logic [WIDTH-1:0] dbg_g,
    output logic [WIDTH-1:0] dbg_t
`endif
);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_s;
    logic             w_cout;

    logic [WIDTH-1:0] r_sum_p1;
    logic             r_carry_p1;
    logic             r_vld_p1;

    // Stage p0: combinational ripple, carry threaded through a block-local variable
    always_comb begin : ripple
        logic w_cy;
        w_p    = '0;
        w_g    = '0;
        w_t    = '0;
        w_s    = '0;
        w_cy   = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_p[i] = a[i] ^ b[i];
            w_g[i] = a[i] & b[i];
            w_s[i] = w_p[i] ^ w_cy;
            w_t[i] = w_p[i] & w_cy;
            w_cy   = w_g[i] | w_t[i];
        end
        w_cout = w_cy;
    end

    // Stage p1: output register; data only loads on enabled edges so X inputs stay out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= en;
            if (en) begin
                r_sum_p1   <= w_s;
                r_carry_p1 <= w_cout;
            end
        end
    end

    assign sum   = r_sum_p1;
    assign carry = r_carry_p1;
    assign valid = r_vld_p1;

`ifdef FULL_ADDER_HALF_DEBUG_EN
    logic [WIDTH-1:0] r_dbg_p_p1;
    logic [WIDTH-1:0] r_dbg_g_p1;
    logic [WIDTH-1:0] r_dbg_t_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_p_p1 <= '0;
            r_dbg_g_p1 <= '0;
            r_dbg_t_p1 <= '0;
        end else if (en) begin
            r_dbg_p_p1 <= w_p;
            r_dbg_g_p1 <= w_g;
            r_dbg_t_p1 <= w_t;
        end
    end

    assign dbg_p = r_dbg_p_p1;
    assign dbg_g = r_dbg_g_p1;
    assign dbg_t = r_dbg_t_p1;
`else
    // Per-bit HA terms stay internal; they are still consumed by the ripple itself.
`endif

endmodule

// File: tb/tb_full_adder_half.sv
// Bench for full_adder_half: WIDTH=1 and WIDTH=8 instances, scoreboard against integer a+b+cin.
// Define FULL_ADDER_HALF_DEBUG_EN to also check the debug taps.
module tb_full_adder_half;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en1, a1, b1, c1;
    logic       sum1, carry1, valid1;
    logic       en8, c8;
    logic [7:0] a8, b8, sum8;
    logic       carry8, valid8;
`ifdef FULL_ADDER_HALF_DEBUG_EN
    logic       dp1, dg1, dt1;
    logic [7:0] dp8, dg8, dt8;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] exp1 [0:63];
    int         wr1 = 0;
    int         rd1 = 0;
    logic [8:0] exp8 [0:2047];
    int         wr8 = 0;
    int         rd8 = 0;

    full_adder_half #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .a(a1), .b(b1), .cin(c1),
        .sum(sum1), .carry(carry1), .valid(valid1)
`ifdef FULL_ADDER_HALF_DEBUG_EN
        , .dbg_p(dp1), .dbg_g(dg1), .dbg_t(dt1)
`endif
    );

    full_adder_half #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .a(a8), .b(b8), .cin(c8),
        .sum(sum8), .carry(carry8), .valid(valid8)
`ifdef FULL_ADDER_HALF_DEBUG_EN
        , .dbg_p(dp8), .dbg_g(dg8), .dbg_t(dt8)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the result is simply the integer sum of the operands
    task automatic push1();
        int s;
        s = int'(a1) + int'(b1) + int'(c1);
        exp1[wr1] = 2'(s);
        wr1++;
    endtask

    task automatic push8();
        int s;
        s = int'(a8) + int'(b8) + int'(c8);
        exp8[wr8] = 9'(s);
        wr8++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog timeout");
    end

    // Monitors: valid must equal en seen at the previous edge; outputs hold between results
    initial begin
        logic       prev;
        logic [1:0] held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_vld1", 64'(valid1), 64'(0));
                chk("rst_out1", 64'({carry1, sum1}), 64'(0));
                held = '0;
                rd1  = wr1;
            end else begin
                chk("vld1", 64'(valid1), 64'(prev));
                if (valid1) begin
                    chk("pending1", 64'(rd1 < wr1), 64'(1));
                    if (rd1 < wr1) begin
                        held = exp1[rd1];
                        rd1++;
                    end
                end
                chk("out1", 64'({carry1, sum1}), 64'(held));
            end
            prev = en1;
        end
    end

    initial begin
        logic       prev;
        logic [8:0] held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_vld8", 64'(valid8), 64'(0));
                chk("rst_out8", 64'({carry8, sum8}), 64'(0));
                held = '0;
                rd8  = wr8;
            end else begin
                chk("vld8", 64'(valid8), 64'(prev));
                if (valid8) begin
                    chk("pending8", 64'(rd8 < wr8), 64'(1));
                    if (rd8 < wr8) begin
                        held = exp8[rd8];
                        rd8++;
                    end
                end
                chk("out8", 64'({carry8, sum8}), 64'(held));
            end
            prev = en8;
        end
    end

    // Driver
    initial begin
        rst_n = 1'b0;
        en1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        en8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        chk("reset_out8", 64'({valid8, carry8, sum8}), 64'(0));
        chk("reset_out1", 64'({valid1, carry1, sum1}), 64'(0));

        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; c1 = v[0]; en1 = 1'b1;
            push1();
            cyc();
        end

        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en1 = 1'b1;
        push1();
        cyc();
        en1 = 1'b0;
        chk("load111", 64'({carry1, sum1}), 64'(2'b11));
`ifdef FULL_ADDER_HALF_DEBUG_EN
        chk("dbg_p", 64'(dp1), 64'(0));
        chk("dbg_g", 64'(dg1), 64'(1));
        chk("dbg_t", 64'(dt1), 64'(0));
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst1", 64'({valid1, carry1, sum1}), 64'(0));
        chk("async_rst8", 64'({valid8, carry8, sum8}), 64'(0));
`ifdef FULL_ADDER_HALF_DEBUG_EN
        chk("async_rst_dbg", 64'({dp1, dg1, dt1}), 64'(0));
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cyc();

        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; en1 = 1'b1;
        push1();
        cyc();
        en1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        chk("hold_load", 64'({carry1, sum1}), 64'(2'b10));
        repeat (3) cyc();
        chk("hold_end", 64'({valid1, carry1, sum1}), 64'(3'b010));

        en8 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; push8(); cyc();
        chk("bnd_ff_01", 64'({carry8, sum8}), 64'(9'h100));
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; push8(); cyc();
        chk("bnd_ff_ff_1", 64'({carry8, sum8}), 64'(9'h1FF));
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; push8(); cyc();
        chk("bnd_zero", 64'({carry8, sum8}), 64'(9'h000));
        en8 = 1'b0;
        cyc();

        for (int i = 0; i < 1000; i++) begin
            en8 = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            if (en8) push8();
            cyc();
        end
        en8 = 1'b0;
        repeat (3) cyc();

        chk("drain1", 64'(rd1), 64'(wr1));
        chk("drain8", 64'(rd8), 64'(wr8));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
